// File: rtl/uproc_pkg.sv
// Shared definitions for the micro-sequencer codebase: program-counter operation
// encoding and the default address width.
package uproc_pkg;

    localparam int PC_AW = 5;

    typedef enum logic [2:0] {
        PC_HOLD,
        PC_INC,
        PC_JMP,
        PC_BR,
        PC_CALL,
        PC_RET
    } pc_op_t;

endpackage

// File: rtl/program_sequencer_return_stack.sv
// LIFO of return addresses for the program sequencer. Push on full and pop on
// empty are silently ignored here; the parent decides how to flag them.
module return_stack #(
    parameter  int DEPTH = 4,
    parameter  int W     = 8,
    localparam int SPW   = $clog2(DEPTH + 1)
) (
    input  logic           clk,
    input  logic           nReset,
    input  logic           push,
    input  logic           pop,
    input  logic [W-1:0]   din,
    output logic [W-1:0]   dout,
    output logic           full,
    output logic           empty,
    output logic [SPW-1:0] sp
);

    logic [W-1:0] mem [DEPTH];

    assign full  = (sp == SPW'(DEPTH));
    assign empty = (sp == '0);

    // Top of stack is the entry just below sp; reads as zero when empty.
    always_comb begin
        dout = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sp == SPW'(i + 1)) dout = mem[i];
        end
    end

    always_ff @(posedge clk) begin
        if (nReset) begin
            sp <= '0;
            // NOTE: the entries are cleared on reset so a stale return address can never
            // reappear after a restart; the array is small enough for flops, not a RAM.
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (pop && !empty) begin
            sp <= sp - SPW'(1);
        end else if (push && !full) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (sp == SPW'(i)) mem[i] <= din;
            end
            sp <= sp + SPW'(1);
        end
    end

endmodule

// File: rtl/program_sequencer.sv
// Program counter with increment, stall, jump, relative branch and call/return
// through an internal return-address stack. addr is fully registered.
module program_sequencer
    import uproc_pkg::*;
#(
    parameter int             AW         = PC_AW,
    parameter int             OFFW       = 4,
    parameter int             RAS_DEPTH  = 4,
    parameter logic [AW-1:0]  RESET_ADDR = '0
) (
    input  logic            clk,
    input  logic            nReset,
    input  logic            en,
    input  logic            jmp,
    input  logic            br,
    input  logic            call,
    input  logic            ret,
    input  logic [AW-1:0]   tgt,
    input  logic [OFFW-1:0] off,
    output logic [AW-1:0]   addr,
    output logic            ras_full,
    output logic            ras_empty,
    output logic            err_ovf,
    output logic            err_unf
);

    localparam int SPW = $clog2(RAS_DEPTH + 1);

    pc_op_t          op;
    logic [AW-1:0]   next_seq;
    logic [AW-1:0]   off_ext;
    logic [AW-1:0]   ras_top;
    logic [SPW-1:0]  ras_sp;
    logic            push;
    logic            pop;

    assign next_seq = addr + AW'(1);
    assign off_ext  = AW'($signed(off));

    // Single-winner priority: ret > call > jmp > br > increment.
    always_comb begin
        // NOTE: op gets a value on every path before any branch, so no latch is inferred.
        op = PC_HOLD;
        if (en) begin
            if (ret)       op = PC_RET;
            else if (call) op = PC_CALL;
            else if (jmp)  op = PC_JMP;
            else if (br)   op = PC_BR;
            else           op = PC_INC;
        end
    end

    assign push = (op == PC_CALL) && !ras_full;
    assign pop  = (op == PC_RET)  && !ras_empty;

    return_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (AW)
    ) u_ras (
        .clk    (clk),
        .nReset (nReset),
        .push   (push),
        .pop    (pop),
        .din    (next_seq),
        .dout   (ras_top),
        .full   (ras_full),
        .empty  (ras_empty),
        .sp     (ras_sp)
    );

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples
        // the pre-edge values regardless of statement order.
        if (nReset) begin
            addr    <= RESET_ADDR;
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else begin
            unique case (op)
                PC_INC:  addr <= next_seq;
                PC_JMP:  addr <= tgt;
                PC_BR:   addr <= addr + off_ext;
                PC_CALL: begin
                    if (ras_full) begin
                        addr    <= next_seq;
                        err_ovf <= 1'b1;
                    end else begin
                        addr <= tgt;
                    end
                end
                PC_RET: begin
                    if (ras_empty) begin
                        addr    <= next_seq;
                        err_unf <= 1'b1;
                    end else begin
                        addr <= ras_top;
                    end
                end
                default: addr <= addr;
            endcase
        end
    end

    sp_in_range: assert property (@(posedge clk) ras_sp <= SPW'(RAS_DEPTH));

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_program_sequencer;

    localparam int AW    = 5;
    localparam int OFFW  = 4;
    localparam int DEPTH = 2;
    localparam int MOD   = 32;

    logic            clk = 1'b0;
    logic            nReset;
    logic            en, jmp, br, call, ret;
    logic [AW-1:0]   tgt;
    logic [OFFW-1:0] off;
    logic [AW-1:0]   addr;
    logic            ras_full, ras_empty, err_ovf, err_unf;

    int checks = 0;
    int errors = 0;

    program_sequencer #(
        .AW         (AW),
        .OFFW       (OFFW),
        .RAS_DEPTH  (DEPTH),
        .RESET_ADDR ('0)
    ) dut (
        .clk       (clk),
        .nReset    (nReset),
        .en        (en),
        .jmp       (jmp),
        .br        (br),
        .call      (call),
        .ret       (ret),
        .tgt       (tgt),
        .off       (off),
        .addr      (addr),
        .ras_full  (ras_full),
        .ras_empty (ras_empty),
        .err_ovf   (err_ovf),
        .err_unf   (err_unf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: PC as an integer, return stack as a queue.
    int  m_pc;
    int  m_stk[$];
    bit  m_ovf, m_unf;
    bit  m_valid = 1'b0;

    always @(posedge clk) begin
        int soff;
        if (nReset) begin
            m_pc = 0;
            m_stk.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_valid = 1'b1;
        end else if (en) begin
            if (ret) begin
                if (m_stk.size() == 0) begin
                    m_unf = 1'b1;
                    m_pc = (m_pc + 1) % MOD;
                end else begin
                    m_pc = m_stk.pop_back();
                end
            end else if (call) begin
                if (m_stk.size() == DEPTH) begin
                    m_ovf = 1'b1;
                    m_pc = (m_pc + 1) % MOD;
                end else begin
                    m_stk.push_back((m_pc + 1) % MOD);
                    m_pc = int'(tgt);
                end
            end else if (jmp) begin
                m_pc = int'(tgt);
            end else if (br) begin
                soff = (int'(off) >= 8) ? int'(off) - 16 : int'(off);
                m_pc = (m_pc + soff + MOD) % MOD;
            end else begin
                m_pc = (m_pc + 1) % MOD;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("addr",      addr,      m_pc);
            check("ras_full",  ras_full,  m_stk.size() == DEPTH);
            check("ras_empty", ras_empty, m_stk.size() == 0);
            check("err_ovf",   err_ovf,   m_ovf);
            check("err_unf",   err_unf,   m_unf);
        end
    end

    task automatic cyc(input logic e, input logic j, input logic b, input logic c,
                       input logic r, input logic [AW-1:0] t, input logic [OFFW-1:0] o);
        en = e; jmp = j; br = b; call = c; ret = r; tgt = t; off = o;
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input logic [AW-1:0] t);
        cyc(1, 1, 0, 0, 0, t, '0);
    endtask

    initial begin
        nReset = 1'b1;
        en = 0; jmp = 0; br = 0; call = 0; ret = 0; tgt = '0; off = '0;

        // Reset for two cycles
        cyc(0, 0, 0, 0, 0, '0, '0);
        cyc(0, 0, 0, 0, 0, '0, '0);
        nReset = 1'b0;
        check("rst_addr",  addr, 0);
        check("rst_empty", ras_empty, 1);
        check("rst_full",  ras_full, 0);
        check("rst_errs",  {err_ovf, err_unf}, 0);

        // Free-running increment with wrap
        for (int k = 1; k <= 33; k++) begin
            cyc(1, 0, 0, 0, 0, '0, '0);
            check("inc", addr, k % MOD);
        end
        check("inc_errs", {err_ovf, err_unf}, 0);

        // Stall ignores strobes
        goto(10);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 1, 0, 0, 0, 5'd3, '0);
            check("stall_hold", addr, 10);
        end
        cyc(1, 1, 0, 0, 0, 5'd3, '0);
        check("stall_release", addr, 3);

        // Relative branch both directions, jmp beats br
        goto(2);
        cyc(1, 0, 1, 0, 0, '0, 4'b1101);
        check("br_neg_wrap", addr, 31);
        cyc(1, 0, 1, 0, 0, '0, 4'd7);
        check("br_pos_wrap", addr, 6);
        cyc(1, 1, 1, 0, 0, 5'd20, 4'd7);
        check("jmp_over_br", addr, 20);

        // Call/return, overflow and underflow
        goto(4);
        cyc(1, 0, 0, 1, 0, 5'd12, '0);
        check("call1_addr", addr, 12);
        check("call1_sp1", {ras_full, ras_empty}, 2'b00);
        cyc(1, 0, 0, 1, 0, 5'd20, '0);
        check("call2_addr", addr, 20);
        check("call2_full", ras_full, 1);
        cyc(1, 0, 0, 1, 0, 5'd25, '0);
        check("ovf_addr", addr, 21);
        check("ovf_flag", err_ovf, 1);
        cyc(1, 0, 0, 0, 1, '0, '0);
        check("ret1_addr", addr, 13);
        cyc(1, 0, 0, 0, 1, '0, '0);
        check("ret2_addr", addr, 5);
        check("ret2_empty", ras_empty, 1);
        cyc(1, 0, 0, 0, 1, '0, '0);
        check("unf_addr", addr, 6);
        check("unf_flag", err_unf, 1);

        // call and ret together: ret wins, no push
        goto(8);
        cyc(1, 0, 0, 1, 0, 5'd14, '0);
        check("pre_cr_addr", addr, 14);
        cyc(1, 0, 0, 1, 1, 5'd27, '0);
        check("cr_addr", addr, 9);
        check("cr_empty", ras_empty, 1);

        // Reset during a call
        goto(7);
        nReset = 1'b1;
        cyc(1, 0, 0, 1, 0, 5'd20, '0);
        nReset = 1'b0;
        check("rstcall_addr", addr, 0);
        check("rstcall_empty", ras_empty, 1);
        check("rstcall_errs", {err_ovf, err_unf}, 0);
        cyc(1, 0, 0, 0, 1, '0, '0);
        check("rstcall_nopush", addr, 1);
        check("rstcall_unf", err_unf, 1);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            nReset = ($urandom_range(0, 149) == 0);
            cyc($urandom_range(0, 9) != 0,
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 2) == 0,
                $urandom_range(0, 2) == 0,
                $urandom_range(0, 3) == 0,
                AW'($urandom),
                OFFW'($urandom));
        end
        nReset = 1'b0;
        cyc(0, 0, 0, 0, 0, '0, '0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
